// File: rtl/program_sequencer.sv
// Program sequencer: holds a small instruction program and paces the processor datapath
// through it with TICK strobes, either free-running off a divider or single-stepped.
module program_sequencer #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned STEP_DIV = 25_000_000
) (
    input  logic              CLK50M,
    input  logic              CLR,
    input  logic              LOAD,
    input  logic [9:0]        D,
    input  logic              RUN,
    input  logic              STEP,
    input  logic              DONE,
    output logic              TICK,
    output logic [9:0]        IR_OUT,
    output logic              INST_VALID,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W:0]   LEN,
    output logic              FULL,
    output logic              HALTED,
    output logic              ERR
);

    localparam int unsigned INST_W = 10;
    localparam int unsigned DIV_W  = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned STEP_W = 3;

    localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W+1)'(DEPTH);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(STEP_DIV - 1);
    localparam logic [STEP_W-1:0] WDOG_LIMIT = STEP_W'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic                issue_first_q, issue_first_d;
    logic                tick_q, tick_d;
    logic [INST_W-1:0]   ir_q, ir_d;
    logic                inst_valid_q, inst_valid_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                full_q, full_d;
    logic                halted_q, halted_d;
    logic                err_q, err_d;

    logic                trigger_c;
    logic                last_inst_c;
    logic                mem_we_c;

    logic [INST_W-1:0]   mem [DEPTH];

    // Program memory: written only while loading, never cleared by reset.
    always_ff @(posedge CLK50M) begin
        if (mem_we_c) begin
            mem[len_q[ADDR_W-1:0]] <= D;
        end
    end

    // Next-state, timestep pacing and output computation.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        step_cnt_d  = step_cnt_q;
        tick_d      = 1'b0;
        ir_d        = ir_q;
        pc_d        = pc_q;
        len_d       = len_q;
        err_d       = err_q;
        mem_we_c    = 1'b0;

        trigger_c   = RUN ? (div_q == DIV_LAST) : STEP;
        last_inst_c = ({1'b0, pc_q} == (len_q - (ADDR_W+1)'(1)));

        // Divider holds at zero through the first ISSUE cycle, so the boundary gap is one longer.
        if (!RUN || issue_first_q || (div_q == DIV_LAST)) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                pc_d = '0;
                if (LOAD) begin
                    if (len_q < DEPTH_L) begin
                        mem_we_c = 1'b1;
                        len_d    = len_q + (ADDR_W+1)'(1);
                    end
                end else if (trigger_c && (len_q != '0)) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ir_d       = mem[pc_q];
                step_cnt_d = '0;
                if (trigger_c) begin
                    tick_d     = 1'b1;
                    step_cnt_d = STEP_W'(1);
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                if (trigger_c) begin
                    tick_d     = 1'b1;
                    step_cnt_d = step_cnt_q + STEP_W'(1);
                    if (DONE) begin
                        if (last_inst_c) begin
                            state_d = S_HALT;
                        end else begin
                            pc_d    = pc_q + ADDR_W'(1);
                            state_d = S_ISSUE;
                        end
                    end else if (step_cnt_d == WDOG_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (!RUN && STEP) begin
                    state_d = S_IDLE;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        issue_first_d = (state_d == S_ISSUE) && (state_q != S_ISSUE);
        inst_valid_d  = (state_q == S_ISSUE) || (state_q == S_EXEC);
        halted_d      = (state_d == S_HALT);
        full_d        = (len_d == DEPTH_L);
    end

    // State and registered outputs.
    always_ff @(posedge CLK50M or posedge CLR) begin
        if (CLR) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            step_cnt_q    <= '0;
            issue_first_q <= 1'b0;
            tick_q        <= 1'b0;
            ir_q          <= '0;
            inst_valid_q  <= 1'b0;
            pc_q          <= '0;
            len_q         <= '0;
            full_q        <= 1'b0;
            halted_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            step_cnt_q    <= step_cnt_d;
            issue_first_q <= issue_first_d;
            tick_q        <= tick_d;
            ir_q          <= ir_d;
            inst_valid_q  <= inst_valid_d;
            pc_q          <= pc_d;
            len_q         <= len_d;
            full_q        <= full_d;
            halted_q      <= halted_d;
            err_q         <= err_d;
        end
    end

    assign TICK       = tick_q;
    assign IR_OUT     = ir_q;
    assign INST_VALID = inst_valid_q;
    assign PC         = pc_q;
    assign LEN        = len_q;
    assign FULL       = full_q;
    assign HALTED     = halted_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: random programs run against a tick-level program model,
// with a controller model that raises DONE on each instruction's chosen completing tick.
`timescale 1ns/1ps
module tb_program_sequencer;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int          SD     = 4;

    logic              clk  = 1'b0;
    logic              rst  = 1'b1;
    logic              load = 1'b0;
    logic [9:0]        d    = '0;
    logic              run  = 1'b0;
    logic              step = 1'b0;
    logic              done = 1'b0;
    logic              tick;
    logic [9:0]        ir_out;
    logic              inst_valid;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W:0]   len;
    logic              full;
    logic              halted;
    logic              err;

    program_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .STEP_DIV(SD)) dut (
        .CLK50M(clk), .CLR(rst), .LOAD(load), .D(d), .RUN(run), .STEP(step), .DONE(done),
        .TICK(tick), .IR_OUT(ir_out), .INST_VALID(inst_valid), .PC(pc), .LEN(len),
        .FULL(full), .HALTED(halted), .ERR(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    // Observed ticks, plus the processor-controller model that drives DONE.
    int         tick_cyc[$];
    logic [9:0] tick_ir[$];
    int         tick_pc[$];
    int         ctl_k[$];
    int         ctl_idx  = 0;
    int         ctl_cnt  = 0;
    int         ctl_gen  = 0;
    int         ctl_seen = 0;

    always @(negedge clk) begin
        if (ctl_gen != ctl_seen) begin
            ctl_seen = ctl_gen;
            ctl_idx  = 0;
            ctl_cnt  = 0;
        end
        if (tick === 1'b1) begin
            tick_cyc.push_back(cyc);
            tick_ir.push_back(ir_out);
            tick_pc.push_back(int'(pc));
            ctl_cnt++;
            if (ctl_idx < ctl_k.size() && ctl_cnt == ctl_k[ctl_idx]) begin
                ctl_idx++;
                ctl_cnt = 0;
            end
        end
        done = (ctl_idx < ctl_k.size()) && (ctl_cnt == ctl_k[ctl_idx] - 1);
    end

    // Program under test and its expected tick trace.
    logic [9:0] prog[$];
    int         kq[$];
    logic [9:0] exp_ir[$];
    int         exp_pc[$];
    int         exp_gap[$];
    bit         exp_err;

    task automatic model_program(input int n);
        exp_ir.delete();
        exp_pc.delete();
        exp_gap.delete();
        exp_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            int nt;
            nt = (kq[i] > 4) ? 4 : kq[i];
            for (int j = 1; j <= nt; j++) begin
                exp_ir.push_back(prog[i]);
                exp_pc.push_back((j == kq[i] && i != n - 1) ? i + 1 : i);
                exp_gap.push_back(exp_ir.size() == 1 ? 0 : (j == 1 ? SD + 1 : SD));
            end
            if (kq[i] > 4) begin
                exp_err = 1'b1;
                break;
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0; step = 1'b0; run = 1'b0;
        cycles(3);
        rst = 1'b0;
        ctl_k.delete();
        ctl_gen++;
        cycles(1);
    endtask

    task automatic load_word(input logic [9:0] w);
        @(posedge clk); #1 load = 1'b1; d = w;
        @(posedge clk); #1 load = 1'b0;
    endtask

    task automatic pulse_step();
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
    endtask

    task automatic setup_ctl();
        ctl_k = kq;
        ctl_gen++;
        cycles(1);
    endtask

    task automatic wait_halted(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        cycles(2);
    endtask

    task automatic wait_ticks(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (tick_cyc.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic step_until_halt(input int max_steps, output int nsteps);
        nsteps = 0;
        while (halted !== 1'b1 && nsteps < max_steps) begin
            pulse_step();
            cycles(3);
            nsteps++;
        end
        cycles(2);
    endtask

    task automatic test_reset();
        cycles(2);
        n_tests++;
        if (tick !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: tick=%b valid=%b halted=%b err=%b, expected all 0", tick, inst_valid, halted, err);
        end
        n_tests++;
        if (ir_out !== 10'h000 || pc !== '0 || len !== '0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: ir=%h pc=%0d len=%0d full=%b, expected 0", ir_out, pc, len, full);
        end
        do_reset();
    endtask

    task automatic test_single_step();
        int base, ns;
        do_reset();
        prog = '{10'h041, 10'h182};
        kq   = '{2, 2};
        load_word(prog[0]);
        load_word(prog[1]);
        n_tests++;
        if (len !== 5'd2 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL step_len: len=%0d full=%b, expected 2 0", len, full);
        end
        model_program(2);
        setup_ctl();
        base = tick_cyc.size();
        pulse_step();
        cycles(3);
        n_tests++;
        if (inst_valid !== 1'b1 || ir_out !== prog[0] || tick_cyc.size() !== base) begin
            n_fail++;
            $display("FAIL step_issue: valid=%b ir=%h ticks=%0d, expected 1 %h 0", inst_valid, ir_out, tick_cyc.size() - base, prog[0]);
        end
        step_until_halt(10, ns);
        n_tests++;
        if (ns + 1 !== exp_ir.size() + 1 || tick_cyc.size() - base !== exp_ir.size()) begin
            n_fail++;
            $display("FAIL step_count: steps=%0d ticks=%0d, expected %0d %0d", ns + 1, tick_cyc.size() - base, exp_ir.size() + 1, exp_ir.size());
        end
        for (int i = 0; i < exp_ir.size() && base + i < tick_cyc.size(); i++) begin
            n_tests++;
            if (tick_ir[base + i] !== exp_ir[i] || tick_pc[base + i] !== exp_pc[i]) begin
                n_fail++;
                $display("FAIL step_tick%0d: ir=%h pc=%0d, expected %h %0d", i, tick_ir[base + i], tick_pc[base + i], exp_ir[i], exp_pc[i]);
            end
        end
        n_tests++;
        if (halted !== 1'b1 || inst_valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL step_end: halted=%b valid=%b err=%b, expected 1 0 0", halted, inst_valid, err);
        end
    endtask

    task automatic test_run_mode(input int n, input int kmode, input bit do_load);
        int base;
        bit ok;
        if (do_load) begin
            do_reset();
            prog.delete();
            for (int i = 0; i < n; i++) begin
                prog.push_back(10'($urandom));
                load_word(prog[i]);
            end
        end
        kq.delete();
        for (int i = 0; i < n; i++)
            kq.push_back(kmode == 0 ? 3 : (kmode == 2 ? 2 : int'($urandom_range(4, 2))));
        model_program(n);
        setup_ctl();
        base = tick_cyc.size();
        run = 1'b1;
        wait_halted(n * 4 * (SD + 2) + 40, ok);
        run = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL run_timeout: halted=%b after budget, expected 1 (n=%0d)", halted, n);
        end
        n_tests++;
        if (tick_cyc.size() - base !== exp_ir.size()) begin
            n_fail++;
            $display("FAIL run_ticks: got %0d ticks, expected %0d (n=%0d)", tick_cyc.size() - base, exp_ir.size(), n);
        end
        for (int i = 0; i < exp_ir.size() && base + i < tick_cyc.size(); i++) begin
            int gap;
            gap = (i == 0) ? 0 : tick_cyc[base + i] - tick_cyc[base + i - 1];
            n_tests++;
            if (tick_ir[base + i] !== exp_ir[i] || tick_pc[base + i] !== exp_pc[i] || gap !== exp_gap[i]) begin
                n_fail++;
                $display("FAIL run_tick%0d: ir=%h pc=%0d gap=%0d, expected %h %0d %0d", i, tick_ir[base + i], tick_pc[base + i], gap, exp_ir[i], exp_pc[i], exp_gap[i]);
            end
        end
        n_tests++;
        if (err !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL run_end: err=%b valid=%b, expected 0 0", err, inst_valid);
        end
    endtask

    task automatic test_full();
        int base;
        do_reset();
        base = tick_cyc.size();
        pulse_step();
        cycles(4);
        n_tests++;
        if (tick_cyc.size() !== base || inst_valid !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_step: ticks=%0d valid=%b halted=%b, expected 0 0 0", tick_cyc.size() - base, inst_valid, halted);
        end
        prog.delete();
        for (int i = 0; i < 16; i++) begin
            prog.push_back(10'($urandom));
            load_word(prog[i]);
            if (i == 14) begin
                n_tests++;
                if (len !== 5'd15 || full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load15: len=%0d full=%b, expected 15 0", len, full);
                end
            end
        end
        n_tests++;
        if (len !== 5'd16 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL load16: len=%0d full=%b, expected 16 1", len, full);
        end
        load_word(~prog[15]);
        n_tests++;
        if (len !== 5'd16 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL load17: len=%0d full=%b, expected 16 1", len, full);
        end
        test_run_mode(16, 2, 1'b0);
    endtask

    task automatic test_watchdog();
        int base, ns;
        do_reset();
        prog = '{10'($urandom), 10'($urandom)};
        kq   = '{5, 2};
        load_word(prog[0]);
        load_word(prog[1]);
        model_program(2);
        setup_ctl();
        base = tick_cyc.size();
        step_until_halt(12, ns);
        n_tests++;
        if (tick_cyc.size() - base !== exp_ir.size() || err !== exp_err || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog: ticks=%0d err=%b halted=%b, expected %0d %b 1", tick_cyc.size() - base, err, halted, exp_ir.size(), exp_err);
        end
        for (int i = 0; i < exp_ir.size() && base + i < tick_cyc.size(); i++) begin
            n_tests++;
            if (tick_ir[base + i] !== exp_ir[i] || tick_pc[base + i] !== exp_pc[i]) begin
                n_fail++;
                $display("FAIL wdog_tick%0d: ir=%h pc=%0d, expected %h %0d", i, tick_ir[base + i], tick_pc[base + i], exp_ir[i], exp_pc[i]);
            end
        end
        load_word(10'($urandom));
        n_tests++;
        if (len !== 5'd2) begin
            n_fail++;
            $display("FAIL halt_load: len=%0d, expected 2", len);
        end
        pulse_step();
        cycles(3);
        n_tests++;
        if (halted !== 1'b0 || err !== 1'b0 || len !== 5'd2 || pc !== '0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_exit: halted=%b err=%b len=%0d pc=%0d valid=%b, expected 0 0 2 0 0", halted, err, len, pc, inst_valid);
        end
    endtask

    task automatic test_simultaneous();
        int base;
        bit ok;
        do_reset();
        load_word(10'h155);
        base = tick_cyc.size();
        @(posedge clk); #1 load = 1'b1; d = 10'h2AA; step = 1'b1;
        @(posedge clk); #1 load = 1'b0; step = 1'b0;
        cycles(4);
        n_tests++;
        if (len !== 5'd2 || tick_cyc.size() !== base || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_step: len=%0d ticks=%0d valid=%b, expected 2 0 0", len, tick_cyc.size() - base, inst_valid);
        end
        kq = '{3, 3};
        setup_ctl();
        base = tick_cyc.size();
        run = 1'b1;
        wait_ticks(base + 2, 60, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL clr_wait: ticks=%0d, expected 2", tick_cyc.size() - base);
        end
        cycles(1);
        #1 rst = 1'b1;
        base = tick_cyc.size();
        #1;
        n_tests++;
        if (len !== '0 || inst_valid !== 1'b0 || tick !== 1'b0 || pc !== '0 || ir_out !== '0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_async: len=%0d valid=%b tick=%b pc=%0d ir=%h halted=%b, expected all 0", len, inst_valid, tick, pc, ir_out, halted);
        end
        cycles(2);
        rst = 1'b0;
        cycles(20);
        n_tests++;
        if (tick_cyc.size() !== base) begin
            n_fail++;
            $display("FAIL clr_noticks: got %0d ticks after reset, expected 0", tick_cyc.size() - base);
        end
        run = 1'b0;
        ctl_gen++;
        cycles(1);
    endtask

    task automatic test_run_drop();
        int base;
        bit ok;
        do_reset();
        prog = '{10'($urandom)};
        kq   = '{3};
        load_word(prog[0]);
        setup_ctl();
        base = tick_cyc.size();
        run = 1'b1;
        wait_ticks(base + 1, 40, ok);
        run = 1'b0;
        cycles(20);
        n_tests++;
        if (!ok || tick_cyc.size() !== base + 1) begin
            n_fail++;
            $display("FAIL drop_hold: ticks=%0d, expected 1", tick_cyc.size() - base);
        end
        pulse_step();
        cycles(3);
        n_tests++;
        if (tick_cyc.size() !== base + 2 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_step1: ticks=%0d halted=%b, expected 2 0", tick_cyc.size() - base, halted);
        end
        pulse_step();
        cycles(3);
        n_tests++;
        if (tick_cyc.size() !== base + 3 || halted !== 1'b1 || tick_ir[tick_cyc.size() - 1] !== prog[0]) begin
            n_fail++;
            $display("FAIL drop_step2: ticks=%0d halted=%b, expected 3 1", tick_cyc.size() - base, halted);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_run_mode(3, 0, 1'b1);
        test_run_mode(5, 1, 1'b1);
        test_run_mode(int'($urandom_range(6, 1)), 1, 1'b1);
        test_full();
        test_watchdog();
        test_simultaneous();
        test_run_drop();
        test_run_mode(int'($urandom_range(8, 2)), 1, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400_000;
        $display("FAIL global_timeout: bench still running at %0t, expected to finish", $time);
        $fatal(1, "bench timeout");
    end

endmodule
